// File: rtl/tcb_pkg.sv
// Shared TCB bus types: request/response payloads, backpressure states and a
// byte-enable expansion helper used by TCB subordinates.
package tcb_pkg;

    localparam int unsigned TCB_AW      = 32;
    localparam int unsigned TCB_DW      = 32;
    localparam int unsigned TCB_SW      = 8;
    localparam int unsigned TCB_BW      = TCB_DW / TCB_SW;
    localparam int unsigned TCB_DLY_MAX = 8;

    typedef struct packed {
        logic              wen;
        logic [TCB_AW-1:0] adr;
        logic [TCB_BW-1:0] ben;
        logic [TCB_DW-1:0] wdt;
        logic              lck;
        logic              rpt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_DW-1:0] rdt;
        logic              err;
    } tcb_rsp_t;

    typedef enum logic {
        BP_IDLE,
        BP_WAIT
    } tcb_bp_state_t;

    // Expands one enable bit per byte lane into a full-width data mask.
    function automatic logic [TCB_DW-1:0] tcb_ben_mask(input logic [TCB_BW-1:0] ben);
        logic [TCB_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < TCB_BW; i++) begin
            mask[i*TCB_SW +: TCB_SW] = {TCB_SW{ben[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/tcb_sub_dly.sv
// Fixed-latency response shift register: DLY stages of {valid, payload}.
// Reusable by any TCB subordinate that needs a constant response delay.
module tcb_sub_dly
    import tcb_pkg::*;
#(
    parameter int unsigned DLY = 1,
    parameter int unsigned PW  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_vld,
    input  logic [PW-1:0] in_pld,
    output logic          out_vld,
    output logic [PW-1:0] out_pld
);

    if (DLY < 1 || DLY > TCB_DLY_MAX) begin : g_chk_dly
        $error("tcb_sub_dly: DLY=%0d outside 1..%0d", DLY, TCB_DLY_MAX);
    end

    logic [DLY-1:0] vld_q;
    logic [PW-1:0]  pld_q [DLY];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's value from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DLY; i++) begin
                pld_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= in_vld;
            pld_q[0] <= in_pld;
            for (int i = 1; i < DLY; i++) begin
                vld_q[i] <= vld_q[i-1];
                pld_q[i] <= pld_q[i-1];
            end
        end
    end

    assign out_vld = vld_q[DLY-1];
    assign out_pld = pld_q[DLY-1];

endmodule

// File: rtl/tcb_sub_mem.sv
// TCB subordinate terminating the bus with a byte-enabled memory array,
// programmable request backpressure and a fixed DLY-cycle response.
module tcb_sub_mem
    import tcb_pkg::*;
#(
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    parameter int unsigned SW    = 8,
    parameter int unsigned BW    = DW / SW,
    parameter int unsigned DLY   = 1,
    parameter int unsigned SIZE  = 4096,
    parameter int unsigned STALL = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vld,
    input  logic          wen,
    input  logic [AW-1:0] adr,
    input  logic [BW-1:0] ben,
    input  logic [DW-1:0] wdt,
    input  logic          lck,
    input  logic          rpt,
    output logic          rdy,
    output logic [DW-1:0] rdt,
    output logic          err,
    output logic          rsp
);

    localparam int unsigned OW    = $clog2(BW);
    localparam int unsigned AWI   = $clog2(SIZE);
    localparam int unsigned IW    = AWI - OW;
    localparam int unsigned WORDS = SIZE / BW;
    localparam int unsigned CW    = (STALL > 0) ? $clog2(STALL + 1) : 1;
    localparam logic [CW-1:0] STALL_C = CW'(STALL);

    if (DLY < 1 || DLY > TCB_DLY_MAX) begin : g_chk_dly
        $error("tcb_sub_mem: DLY=%0d outside 1..%0d", DLY, TCB_DLY_MAX);
    end
    if (SIZE == 0 || (SIZE & (SIZE - 1)) != 0) begin : g_chk_size
        $error("tcb_sub_mem: SIZE=%0d is not a power of two", SIZE);
    end
    if (BW * SW != DW) begin : g_chk_bw
        $error("tcb_sub_mem: BW*SW=%0d differs from DW=%0d", BW * SW, DW);
    end
    if (SIZE % BW != 0) begin : g_chk_align
        $error("tcb_sub_mem: SIZE=%0d is not a multiple of BW=%0d", SIZE, BW);
    end
    if (AW != TCB_AW || DW != TCB_DW || SW != TCB_SW) begin : g_chk_struct
        $error("tcb_sub_mem: bus widths must match the tcb_pkg payload structs");
    end

    tcb_req_t         req;
    tcb_rsp_t         rsp_in;
    tcb_rsp_t         rsp_out;
    logic             rsp_vld;
    logic             xfer;
    logic             range_err;
    logic [IW-1:0]    idx;
    logic             unused;

    tcb_bp_state_t    state;
    tcb_bp_state_t    state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

    logic [DW-1:0]    mem [WORDS];

    assign req = '{wen: wen, adr: adr, ben: ben, wdt: wdt, lck: lck, rpt: rpt};

    // Lock/repeat and the sub-word address bits carry no meaning for this memory.
    assign unused = ^{req.lck, req.rpt, req.adr[OW-1:0]};

    // Backpressure: rdy rises only after STALL cycles of continuous vld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BP_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // NOTE: defaults first, so no path through the case leaves a variable
    // unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            BP_IDLE: begin
                if (vld && (STALL > 0)) begin
                    state_nxt = BP_WAIT;
                    cnt_nxt   = CW'(1);
                end
            end
            BP_WAIT: begin
                if (!vld || cnt == STALL_C) begin
                    state_nxt = BP_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = BP_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign rdy  = (STALL == 0) || (state == BP_WAIT && cnt == STALL_C);
    assign xfer = vld && rdy;

    assign range_err = ({1'b0, req.adr} >= (TCB_AW + 1)'(SIZE));
    assign idx       = req.adr[AWI-1:OW];

    // NOTE: the array is deliberately not reset; its contents survive rst
    // and it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (xfer && req.wen && !range_err) begin
            for (int i = 0; i < BW; i++) begin
                if (req.ben[i]) begin
                    mem[idx][i*SW +: SW] <= req.wdt[i*SW +: SW];
                end
            end
        end
    end

    // Read data is captured at the transfer edge; disabled lanes read as zero.
    always_comb begin
        rsp_in     = '0;
        rsp_in.err = range_err;
        if (!req.wen && !range_err) begin
            rsp_in.rdt = mem[idx] & tcb_ben_mask(req.ben);
        end
    end

    tcb_sub_dly #(
        .DLY (DLY),
        .PW  ($bits(tcb_rsp_t))
    ) u_dly (
        .clk     (clk),
        .rst_n   (rst),
        .in_vld  (xfer),
        .in_pld  (rsp_in),
        .out_vld (rsp_vld),
        .out_pld (rsp_out)
    );

    assign rsp = rsp_vld;
    assign rdt = rsp_vld ? rsp_out.rdt : '0;
    assign err = rsp_vld && rsp_out.err;

endmodule
